// File: rtl/mpf_req_credit_shim.sv
// Request shim between AFU CCI-P read/write request streams and the MPF afu port.
// Each channel buffers requests in a FIFO and issues them downstream only when the
// FIU is not almost-full and enough outstanding-line credit remains.

// One request channel: FIFO, credit-gated issue, outstanding/stall/error tracking.
// The request length sits in payload bits [1:0] so the head's line count is visible.
module mpf_req_credit_shim_chan #(
    parameter int PAYLOAD_WIDTH  = 60,
    parameter int FIFO_DEPTH     = 32,
    parameter int ALM_FULL_SLACK = 8,
    parameter int MAX_LINES      = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [PAYLOAD_WIDTH-1:0] push_data,
    input  logic                     fiu_alm_full,
    input  logic [2:0]               rsp_lines,
    output logic                     alm_full,
    output logic                     out_valid,
    output logic [PAYLOAD_WIDTH-1:0] out_data,
    output logic [11:0]              outstanding,
    output logic [31:0]              stall_cycles,
    output logic                     err
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [PAYLOAD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]            wptr;
    logic [PW-1:0]            rptr;
    logic [PW:0]              count;
    logic                     empty;
    logic                     full;
    logic                     do_push;
    logic                     drop;
    logic                     issue;
    logic [2:0]               head_lines;
    logic [12:0]              credit_sum;
    logic [12:0]              after_issue;
    logic                     underflow;
    logic [11:0]              outstanding_next;

    assign empty      = (count == '0);
    assign full       = (count == (PW+1)'(FIFO_DEPTH));
    assign do_push    = push && !full;
    assign drop       = push && full;
    assign head_lines = {1'b0, mem[rptr][1:0]} + 3'd1;
    assign credit_sum = {1'b0, outstanding} + {10'b0, head_lines};
    assign issue      = !empty && !fiu_alm_full && (credit_sum <= 13'(MAX_LINES));

    // Net outstanding change of issue and response; a result below zero clamps to 0.
    always_comb begin
        after_issue      = {1'b0, outstanding} + (issue ? {10'b0, head_lines} : 13'd0);
        underflow        = (after_issue < {10'b0, rsp_lines});
        outstanding_next = '0;
        if (!underflow) begin
            outstanding_next = 12'(after_issue - {10'b0, rsp_lines});
        end
    end

    // FIFO storage; no reset needed since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // FIFO pointers, occupancy and registered almost-full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            alm_full <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (issue)   rptr <= rptr + 1'b1;
            case ({do_push, issue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            alm_full <= (count >= (PW+1)'(FIFO_DEPTH - ALM_FULL_SLACK));
        end
    end

    // Downstream request register, credits, stall counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            outstanding  <= '0;
            stall_cycles <= '0;
            err          <= 1'b0;
        end else begin
            out_valid   <= issue;
            if (issue) out_data <= mem[rptr];
            outstanding <= outstanding_next;
            if (!empty && !issue && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            err <= err | drop | underflow;
        end
    end
endmodule

// Top: two independent channels, requests always marked virtual.
module mpf_req_credit_shim #(
    parameter int ADDR_WIDTH     = 42,
    parameter int MDATA_WIDTH    = 16,
    parameter int DATA_WIDTH     = 512,
    parameter int FIFO_DEPTH     = 32,
    parameter int ALM_FULL_SLACK = 8,
    parameter int MAX_RD_LINES   = 256,
    parameter int MAX_WR_LINES   = 128
) (
    input  logic                   pClk,
    input  logic                   SoftReset_n,
    input  logic                   rd_req_valid,
    input  logic [ADDR_WIDTH-1:0]  rd_req_addr,
    input  logic [MDATA_WIDTH-1:0] rd_req_mdata,
    input  logic [1:0]             rd_req_len,
    output logic                   rd_alm_full,
    input  logic                   wr_req_valid,
    input  logic [ADDR_WIDTH-1:0]  wr_req_addr,
    input  logic [MDATA_WIDTH-1:0] wr_req_mdata,
    input  logic [1:0]             wr_req_len,
    input  logic [DATA_WIDTH-1:0]  wr_req_data,
    output logic                   wr_alm_full,
    output logic                   fiu_rd_valid,
    output logic [ADDR_WIDTH-1:0]  fiu_rd_addr,
    output logic [MDATA_WIDTH-1:0] fiu_rd_mdata,
    output logic [1:0]             fiu_rd_len,
    output logic                   fiu_rd_is_virtual,
    output logic                   fiu_wr_valid,
    output logic [ADDR_WIDTH-1:0]  fiu_wr_addr,
    output logic [MDATA_WIDTH-1:0] fiu_wr_mdata,
    output logic [1:0]             fiu_wr_len,
    output logic [DATA_WIDTH-1:0]  fiu_wr_data,
    output logic                   fiu_wr_is_virtual,
    input  logic                   fiu_rd_alm_full,
    input  logic                   fiu_wr_alm_full,
    input  logic                   rd_rsp_valid,
    input  logic                   wr_rsp_valid,
    input  logic [2:0]             wr_rsp_lines,
    output logic [11:0]            rd_outstanding,
    output logic [11:0]            wr_outstanding,
    output logic [31:0]            rd_stall_cycles,
    output logic [31:0]            wr_stall_cycles,
    output logic                   rd_err,
    output logic                   wr_err
);
    localparam int RD_W = ADDR_WIDTH + MDATA_WIDTH + 2;
    localparam int WR_W = ADDR_WIDTH + MDATA_WIDTH + DATA_WIDTH + 2;

    logic [RD_W-1:0] rd_out;
    logic [WR_W-1:0] wr_out;

    mpf_req_credit_shim_chan #(
        .PAYLOAD_WIDTH (RD_W),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .ALM_FULL_SLACK(ALM_FULL_SLACK),
        .MAX_LINES     (MAX_RD_LINES)
    ) u_rd (
        .clk         (pClk),
        .rst_n       (SoftReset_n),
        .push        (rd_req_valid),
        .push_data   ({rd_req_addr, rd_req_mdata, rd_req_len}),
        .fiu_alm_full(fiu_rd_alm_full),
        .rsp_lines   ({2'b00, rd_rsp_valid}),
        .alm_full    (rd_alm_full),
        .out_valid   (fiu_rd_valid),
        .out_data    (rd_out),
        .outstanding (rd_outstanding),
        .stall_cycles(rd_stall_cycles),
        .err         (rd_err)
    );

    mpf_req_credit_shim_chan #(
        .PAYLOAD_WIDTH (WR_W),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .ALM_FULL_SLACK(ALM_FULL_SLACK),
        .MAX_LINES     (MAX_WR_LINES)
    ) u_wr (
        .clk         (pClk),
        .rst_n       (SoftReset_n),
        .push        (wr_req_valid),
        .push_data   ({wr_req_addr, wr_req_mdata, wr_req_data, wr_req_len}),
        .fiu_alm_full(fiu_wr_alm_full),
        .rsp_lines   (wr_rsp_valid ? wr_rsp_lines : 3'd0),
        .alm_full    (wr_alm_full),
        .out_valid   (fiu_wr_valid),
        .out_data    (wr_out),
        .outstanding (wr_outstanding),
        .stall_cycles(wr_stall_cycles),
        .err         (wr_err)
    );

    assign {fiu_rd_addr, fiu_rd_mdata, fiu_rd_len}              = rd_out;
    assign {fiu_wr_addr, fiu_wr_mdata, fiu_wr_data, fiu_wr_len} = wr_out;
    assign fiu_rd_is_virtual = fiu_rd_valid;
    assign fiu_wr_is_virtual = fiu_wr_valid;
endmodule

// File: tb/tb_mpf_req_credit_shim.sv
// Scoreboard bench for mpf_req_credit_shim: stimulus queues expected FIU requests,
// a negedge monitor pops and compares them whenever fiu_*_valid is seen.
module tb_mpf_req_credit_shim;
    localparam int AW = 42;
    localparam int MW = 16;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_req_valid = 1'b0;
    logic [AW-1:0] rd_req_addr = '0;
    logic [MW-1:0] rd_req_mdata = '0;
    logic [1:0]    rd_req_len = '0;
    logic          rd_alm_full;
    logic          wr_req_valid = 1'b0;
    logic [AW-1:0] wr_req_addr = '0;
    logic [MW-1:0] wr_req_mdata = '0;
    logic [1:0]    wr_req_len = '0;
    logic [DW-1:0] wr_req_data = '0;
    logic          wr_alm_full;
    logic          fiu_rd_valid, fiu_rd_is_virtual;
    logic [AW-1:0] fiu_rd_addr;
    logic [MW-1:0] fiu_rd_mdata;
    logic [1:0]    fiu_rd_len;
    logic          fiu_wr_valid, fiu_wr_is_virtual;
    logic [AW-1:0] fiu_wr_addr;
    logic [MW-1:0] fiu_wr_mdata;
    logic [1:0]    fiu_wr_len;
    logic [DW-1:0] fiu_wr_data;
    logic          fiu_rd_alm_full = 1'b0;
    logic          fiu_wr_alm_full = 1'b0;
    logic          rd_rsp_valid = 1'b0;
    logic          wr_rsp_valid = 1'b0;
    logic [2:0]    wr_rsp_lines = '0;
    logic [11:0]   rd_outstanding, wr_outstanding;
    logic [31:0]   rd_stall_cycles, wr_stall_cycles;
    logic          rd_err, wr_err;

    int checks = 0;
    int errors = 0;
    logic [AW+MW+2:0]    rd_q [$];
    logic [AW+MW+DW+2:0] wr_q [$];
    logic wr_hold  = 1'b0;
    logic rd_quiet = 1'b0;

    mpf_req_credit_shim #(
        .ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .DATA_WIDTH(DW), .FIFO_DEPTH(32),
        .ALM_FULL_SLACK(8), .MAX_RD_LINES(8), .MAX_WR_LINES(128)
    ) dut (
        .pClk(clk), .SoftReset_n(rst_n),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
        .rd_req_mdata(rd_req_mdata), .rd_req_len(rd_req_len), .rd_alm_full(rd_alm_full),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
        .wr_req_mdata(wr_req_mdata), .wr_req_len(wr_req_len), .wr_req_data(wr_req_data),
        .wr_alm_full(wr_alm_full),
        .fiu_rd_valid(fiu_rd_valid), .fiu_rd_addr(fiu_rd_addr), .fiu_rd_mdata(fiu_rd_mdata),
        .fiu_rd_len(fiu_rd_len), .fiu_rd_is_virtual(fiu_rd_is_virtual),
        .fiu_wr_valid(fiu_wr_valid), .fiu_wr_addr(fiu_wr_addr), .fiu_wr_mdata(fiu_wr_mdata),
        .fiu_wr_len(fiu_wr_len), .fiu_wr_data(fiu_wr_data), .fiu_wr_is_virtual(fiu_wr_is_virtual),
        .fiu_rd_alm_full(fiu_rd_alm_full), .fiu_wr_alm_full(fiu_wr_alm_full),
        .rd_rsp_valid(rd_rsp_valid), .wr_rsp_valid(wr_rsp_valid), .wr_rsp_lines(wr_rsp_lines),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .rd_stall_cycles(rd_stall_cycles), .wr_stall_cycles(wr_stall_cycles),
        .rd_err(rd_err), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Monitor: compare every presented FIU request against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fiu_rd_valid) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got addr=%h mdata=%h, required no request", fiu_rd_addr, fiu_rd_mdata);
                end else begin
                    logic [AW+MW+2:0] exp_r;
                    exp_r = rd_q.pop_front();
                    if ({fiu_rd_addr, fiu_rd_mdata, fiu_rd_len, fiu_rd_is_virtual} !== exp_r) begin
                        errors++;
                        $display("FAIL rd_req: got %h, required %h",
                                 {fiu_rd_addr, fiu_rd_mdata, fiu_rd_len, fiu_rd_is_virtual}, exp_r);
                    end
                end
            end
            if (fiu_wr_valid) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr=%h, required no request", fiu_wr_addr);
                end else begin
                    logic [AW+MW+DW+2:0] exp_w;
                    exp_w = wr_q.pop_front();
                    if ({fiu_wr_addr, fiu_wr_mdata, fiu_wr_len, fiu_wr_data, fiu_wr_is_virtual} !== exp_w) begin
                        errors++;
                        $display("FAIL wr_req: got %h, required %h",
                                 {fiu_wr_addr, fiu_wr_mdata, fiu_wr_len, fiu_wr_data, fiu_wr_is_virtual}, exp_w);
                    end
                end
            end
            if (wr_hold) begin
                checks++;
                if (fiu_wr_valid) begin
                    errors++;
                    $display("FAIL wr_hold: fiu_wr_valid=1, required 0 while FIU almost-full");
                end
            end
            if (rd_quiet) begin
                checks++;
                if (fiu_rd_valid) begin
                    errors++;
                    $display("FAIL rd_quiet: fiu_rd_valid=1, required 0 after reset");
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_push(input logic [AW-1:0] a, input logic [MW-1:0] m,
                           input logic [1:0] l, input bit expect_it);
        rd_req_valid = 1'b1; rd_req_addr = a; rd_req_mdata = m; rd_req_len = l;
        if (expect_it) rd_q.push_back({a, m, l, 1'b1});
        tick();
        rd_req_valid = 1'b0;
    endtask

    task automatic wr_push(input logic [AW-1:0] a, input logic [MW-1:0] m,
                           input logic [1:0] l, input logic [DW-1:0] d, input bit expect_it);
        wr_req_valid = 1'b1; wr_req_addr = a; wr_req_mdata = m; wr_req_len = l; wr_req_data = d;
        if (expect_it) wr_q.push_back({a, m, l, d, 1'b1});
        tick();
        wr_req_valid = 1'b0;
    endtask

    task automatic wr_rsp(input logic [2:0] lines, input int n);
        for (int i = 0; i < n; i++) begin
            wr_rsp_valid = 1'b1; wr_rsp_lines = lines;
            tick();
        end
        wr_rsp_valid = 1'b0; wr_rsp_lines = '0;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        #2;
        chk("reset_fiu_rd_valid", 64'(fiu_rd_valid), 0);
        chk("reset_fiu_wr_valid", 64'(fiu_wr_valid), 0);
        chk("reset_rd_alm_full", 64'(rd_alm_full), 0);
        chk("reset_rd_outstanding", 64'(rd_outstanding), 0);
        chk("reset_wr_err", 64'(wr_err), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Single read: valid two edges after acceptance, one pulse, then credit returned
        rd_push(42'h100, 16'h11, 2'd0, 1'b1);
        tick();
        chk("t1_rd_valid", 64'(fiu_rd_valid), 1);
        chk("t1_rd_outstanding", 64'(rd_outstanding), 1);
        tick();
        chk("t1_rd_valid_pulse", 64'(fiu_rd_valid), 0);
        rd_rsp_valid = 1'b1;
        tick();
        rd_rsp_valid = 1'b0;
        chk("t1_rd_outstanding_ret", 64'(rd_outstanding), 0);

        // Credit limit 8: nine reads, ninth held until one response
        for (int i = 0; i < 9; i++) rd_push(42'h200 + 42'(i), 16'(i), 2'd0, 1'b1);
        tick();
        chk("t2_stall_1", 64'(rd_stall_cycles), 1);
        chk("t2_outstanding_8", 64'(rd_outstanding), 8);
        tick();
        chk("t2_stall_2", 64'(rd_stall_cycles), 2);
        tick();
        chk("t2_stall_3", 64'(rd_stall_cycles), 3);
        rd_rsp_valid = 1'b1;
        tick();
        rd_rsp_valid = 1'b0;
        chk("t2_stall_4", 64'(rd_stall_cycles), 4);
        chk("t2_outstanding_7", 64'(rd_outstanding), 7);
        chk("t2_ninth_not_yet", 64'(fiu_rd_valid), 0);
        tick();
        chk("t2_ninth_issued", 64'(fiu_rd_valid), 1);
        chk("t2_outstanding_back_8", 64'(rd_outstanding), 8);
        chk("t2_stall_hold", 64'(rd_stall_cycles), 4);
        rd_rsp_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        rd_rsp_valid = 1'b0;
        chk("t2_drained", 64'(rd_outstanding), 0);

        // Write FIFO blocked by FIU almost-full: wr_alm_full lag, then in-order drain
        fiu_wr_alm_full = 1'b1;
        wr_hold = 1'b1;
        for (int i = 0; i < 24; i++)
            wr_push(42'h300 + 42'(i), 16'h1000 + 16'(i), 2'd0, 64'hA5A5_0000_0000_0000 + 64'(i), 1'b1);
        chk("t3_alm_full_lag", 64'(wr_alm_full), 0);
        tick();
        chk("t3_alm_full_set", 64'(wr_alm_full), 1);
        fiu_wr_alm_full = 1'b0;
        wr_hold = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("t3_wr_back_to_back", 64'(fiu_wr_valid), 1);
            if (i == 0) chk("t3_alm_full_still", 64'(wr_alm_full), 1);
            if (i == 1) chk("t3_alm_full_clear", 64'(wr_alm_full), 0);
        end
        tick();
        chk("t3_wr_idle", 64'(fiu_wr_valid), 0);
        chk("t3_wr_outstanding", 64'(wr_outstanding), 24);
        wr_rsp(3'd4, 6);
        chk("t3_drained", 64'(wr_outstanding), 0);

        // Net change: len=3 issued, then len=0 issue with a 4-line response
        wr_push(42'h400, 16'h44, 2'd3, 64'h4444, 1'b1);
        wr_push(42'h401, 16'h45, 2'd0, 64'h4545, 1'b1);
        chk("t4_outstanding_4", 64'(wr_outstanding), 4);
        wr_rsp(3'd4, 1);
        chk("t4_outstanding_1", 64'(wr_outstanding), 1);
        wr_rsp(3'd1, 1);
        chk("t4_outstanding_0", 64'(wr_outstanding), 0);
        chk("t4_no_err", 64'(wr_err), 0);

        // Overflow: 33rd write into a blocked 32-entry FIFO is dropped
        fiu_wr_alm_full = 1'b1;
        wr_hold = 1'b1;
        for (int i = 0; i < 33; i++) begin
            wr_push(42'h500 + 42'(i), 16'h2000 + 16'(i), 2'd0, 64'(i) * 64'h0101, i < 32);
            if (i == 31) chk("t5_err_before_drop", 64'(wr_err), 0);
        end
        chk("t5_err_set", 64'(wr_err), 1);
        fiu_wr_alm_full = 1'b0;
        wr_hold = 1'b0;
        for (int i = 0; i < 33; i++) tick();
        chk("t5_outstanding_32", 64'(wr_outstanding), 32);
        wr_rsp(3'd4, 8);
        chk("t5_drained", 64'(wr_outstanding), 0);
        chk("t5_err_sticky", 64'(wr_err), 1);
        wr_rsp(3'd1, 1);
        chk("t5_underflow_sat", 64'(wr_outstanding), 0);

        // Reset with 5 reads outstanding and 3 queued
        for (int i = 0; i < 5; i++) rd_push(42'h600 + 42'(i), 16'h60 + 16'(i), 2'd0, 1'b1);
        tick();
        tick();
        fiu_rd_alm_full = 1'b1;
        for (int i = 0; i < 3; i++) rd_push(42'h700 + 42'(i), 16'h70, 2'd0, 1'b0);
        chk("t6_outstanding_5", 64'(rd_outstanding), 5);
        chk("t6_rd_err_clean", 64'(rd_err), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_fiu_rd_valid", 64'(fiu_rd_valid), 0);
        chk("t6_rst_rd_outstanding", 64'(rd_outstanding), 0);
        chk("t6_rst_rd_stall", 64'(rd_stall_cycles), 0);
        chk("t6_rst_rd_alm_full", 64'(rd_alm_full), 0);
        chk("t6_rst_wr_err", 64'(wr_err), 0);
        chk("t6_rst_wr_stall", 64'(wr_stall_cycles), 0);
        chk("t6_rst_fiu_wr_valid", 64'(fiu_wr_valid), 0);
        rd_quiet = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        fiu_rd_alm_full = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rd_quiet = 1'b0;
        chk("t6_post_outstanding", 64'(rd_outstanding), 0);
        chk("t6_post_err", 64'(rd_err), 0);
        rd_rsp_valid = 1'b1;
        tick();
        rd_rsp_valid = 1'b0;
        chk("t6_late_rsp_count", 64'(rd_outstanding), 0);
        chk("t6_late_rsp_err", 64'(rd_err), 1);

        tick();
        chk("rd_scoreboard_empty", 64'(rd_q.size()), 0);
        chk("wr_scoreboard_empty", 64'(wr_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
